// File: rtl/topk_result_tx.sv
// Top-k result transmitter: buffers search-core results and sends them as a framed 32-bit stream.
// Optional trailer with query cycle count is built when TX_CYCLE_COUNT_EN is defined.
module topk_result_tx #(
    parameter int unsigned K_MAX     = 8,
    parameter logic [31:0] SYNC_WORD = 32'hFFFFFFFF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] result_in,
    input  logic        result_valid_in,
    input  logic        result_last_in,
    input  logic [15:0] k_in,
    input  logic        start_in,
    output logic [31:0] data_out,
    output logic        data_valid_out,
    input  logic        data_ready_in,
    output logic        busy_out,
    output logic        overflow_out
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = $clog2(K_MAX + 1);
    localparam int unsigned AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam logic [DW-1:0] ESC_WORD = DW'(SYNC_WORD - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SEND_SYNC,
        S_SEND_COUNT,
        S_SEND_DATA,
        S_SEND_CYC
    } state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_count, w_count_nx;
    logic [CW-1:0]   r_idx, w_idx_nx;
    logic [15:0]     r_k, w_k_nx;
    logic            r_esc, w_esc_nx;
    logic            r_fovf, w_fovf_nx;
    logic            r_ovf, w_ovf_nx;
    logic [DW-1:0]   r_data, w_data_nx;
    logic            r_valid, w_valid_nx;
    logic            r_busy;
    logic            w_busy;
    logic            w_close;
    logic            w_done;
    logic            w_fire;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_idx;
    logic [DW-1:0]   w_wr_word;
    logic [DW-1:0]   r_buf [K_MAX];

    assign w_busy = (r_state != S_IDLE) && (r_state != S_COLLECT);
    assign w_fire = r_valid && data_ready_in;
    // Escaping happens on capture so the count word already knows about it.
    assign w_wr_word = (result_in == SYNC_WORD) ? ESC_WORD : result_in;

`ifdef TX_CYCLE_COUNT_EN
    logic [DW-1:0] r_cyc;
    logic          r_cyc_run;

    // Query cycle counter; saturates one below the sync word.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cyc     <= '0;
            r_cyc_run <= 1'b0;
        end else if (start_in && !w_busy) begin
            r_cyc     <= '0;
            r_cyc_run <= !w_close;
        end else if (r_cyc_run) begin
            if (r_cyc != 32'hFFFFFFFE) begin
                r_cyc <= r_cyc + 32'd1;
            end
            if (w_close) begin
                r_cyc_run <= 1'b0;
            end
        end
    end
`else
    logic w_unused_start;
    assign w_unused_start = start_in;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_idx_nx   = r_idx;
        w_k_nx     = r_k;
        w_esc_nx   = r_esc;
        w_fovf_nx  = r_fovf;
        w_ovf_nx   = r_ovf;
        w_data_nx  = r_data;
        w_valid_nx = r_valid;
        w_close    = 1'b0;
        w_done     = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_idx   = AW'(r_count);

        case (r_state)
            S_IDLE: begin
                if (result_valid_in) begin
                    w_ovf_nx   = 1'b0;
                    w_fovf_nx  = 1'b0;
                    w_esc_nx   = (result_in == SYNC_WORD);
                    w_wr_en    = 1'b1;
                    w_wr_idx   = '0;
                    w_count_nx = CW'(1);
                    w_k_nx     = k_in;
                    w_close    = result_last_in || (k_in == 16'd1);
                    w_state_nx = S_COLLECT;
                end else if (result_last_in) begin
                    w_ovf_nx   = 1'b0;
                    w_fovf_nx  = 1'b0;
                    w_esc_nx   = 1'b0;
                    w_count_nx = '0;
                    w_close    = 1'b1;
                end
            end
            S_COLLECT: begin
                if (result_valid_in) begin
                    if (r_count == CW'(K_MAX)) begin
                        w_ovf_nx  = 1'b1;
                        w_fovf_nx = 1'b1;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_count_nx = CW'(r_count + 1'b1);
                        if (result_in == SYNC_WORD) begin
                            w_esc_nx = 1'b1;
                        end
                    end
                end
                w_close = result_last_in || ((r_k != 16'd0) && (16'(w_count_nx) == r_k));
            end
            S_SEND_SYNC: begin
                if (w_fire) begin
                    w_data_nx  = {r_esc, r_fovf, 14'd0, 16'(r_count)};
                    w_state_nx = S_SEND_COUNT;
                end
            end
            S_SEND_COUNT: begin
                if (w_fire) begin
                    if (r_count != '0) begin
                        w_data_nx  = r_buf[0];
                        w_idx_nx   = CW'(1);
                        w_state_nx = S_SEND_DATA;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            S_SEND_DATA: begin
                if (w_fire) begin
                    if (r_idx == r_count) begin
                        w_done = 1'b1;
                    end else begin
                        w_data_nx = r_buf[AW'(r_idx)];
                        w_idx_nx  = CW'(r_idx + 1'b1);
                    end
                end
            end
            S_SEND_CYC: begin
                if (w_fire) begin
                    w_state_nx = S_IDLE;
                    w_valid_nx = 1'b0;
                    w_count_nx = '0;
                    w_idx_nx   = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Anything offered while transmitting is lost.
        if (w_busy && (result_valid_in || result_last_in)) begin
            w_ovf_nx = 1'b1;
        end

        if (w_close) begin
            w_state_nx = S_SEND_SYNC;
            w_data_nx  = SYNC_WORD;
            w_valid_nx = 1'b1;
        end

        if (w_done) begin
`ifdef TX_CYCLE_COUNT_EN
            w_state_nx = S_SEND_CYC;
            w_data_nx  = r_cyc;
`else
            w_state_nx = S_IDLE;
            w_valid_nx = 1'b0;
            w_count_nx = '0;
            w_idx_nx   = '0;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_k     <= '0;
            r_esc   <= 1'b0;
            r_fovf  <= 1'b0;
            r_ovf   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_idx   <= w_idx_nx;
            r_k     <= w_k_nx;
            r_esc   <= w_esc_nx;
            r_fovf  <= w_fovf_nx;
            r_ovf   <= w_ovf_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_busy  <= (w_state_nx != S_IDLE) && (w_state_nx != S_COLLECT);
        end
    end

    // Result storage needs no reset; the count qualifies its contents.
    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            r_buf[w_wr_idx] <= w_wr_word;
        end
    end

    assign data_out       = r_data;
    assign data_valid_out = r_valid;
    assign busy_out       = r_busy;
    assign overflow_out   = r_ovf;

endmodule
